// File: rtl/reg_file_arbiter.sv
// rtl/reg_file_arbiter.sv - round-robin arbiter for the register file write port and read port A
//
// Shares the register file write port and read port A between NUM_REQ requesters.
// Each grant gives exactly one access cycle (ACCESS). Read data is registered one cycle later.
// Optional feature macro: REG_ARB_LOCK_EN adds the lock port and the LOCKED state, which
// lets the owner keep the register file for back-to-back accesses.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-low reset
//   req/we         per-requester request and write strobe (1 = write)
//   sel/wdata      per-requester target register and write data
//   lock           per-requester hold-ownership request (REG_ARB_LOCK_EN only)
//   a              register file read port A data
//   gnt            one-hot pulse during the granted ACCESS cycle
//   rvalid/rdata   one-hot read completion pulse and captured read data
//   sel_a/oe_a     register file read port A select and enable
//   sel_in/in/ld   register file write port select, data and load

package reg_file_arbiter_pkg;
  typedef enum logic [2:0] {R0, R1, R2, R3, R4, R5, R6, R7} reg_e;
endpackage

module reg_file_arbiter
  import reg_file_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] we,
  input  reg_e               sel   [NUM_REQ],
  input  logic [31:0]        wdata [NUM_REQ],
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] lock,
`endif
  input  logic [31:0]        a,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] rvalid,
  output logic [31:0]        rdata,
  output reg_e               sel_a,
  output logic               oe_a,
  output reg_e               sel_in,
  output logic [31:0]        in,
  output logic               ld
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ACCESS, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [IDXW-1:0]    owner_q, owner_d;
  logic               we_q, we_d;
  reg_e               sel_q, sel_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
`ifdef REG_ARB_LOCK_EN
  logic               lock_q, lock_d;
`endif

  logic               found;
  logic [IDXW-1:0]    win;
  logic [IDXW-1:0]    cand;

  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Scan from the pointer upward, wrapping; the first active request wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDXW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
`ifdef REG_ARB_LOCK_EN
    lock_d   = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = win;
          we_d    = we[win];
          sel_d   = sel[win];
          wdata_d = wdata[win];
`ifdef REG_ARB_LOCK_EN
          lock_d  = lock[win];
`endif
          // The pointer moves past the winner now; a locked owner never moves it further.
          ptr_d   = next_idx(win);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = a;
        end
`ifdef REG_ARB_LOCK_EN
        state_d = lock_q ? LOCKED : IDLE;
`else
        state_d = IDLE;
`endif
      end
      LOCKED: begin
`ifdef REG_ARB_LOCK_EN
        if (req[owner_q]) begin
          we_d    = we[owner_q];
          sel_d   = sel[owner_q];
          wdata_d = wdata[owner_q];
          lock_d  = lock[owner_q];
          state_d = ACCESS;
        end else if (!lock[owner_q]) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file drive exists only in ACCESS, so the a bus is released otherwise.
  always_comb begin
    gnt    = '0;
    ld     = 1'b0;
    oe_a   = 1'b0;
    sel_a  = R0;
    sel_in = R0;
    in     = '0;
    if (state_q == ACCESS) begin
      gnt[owner_q] = 1'b1;
      if (we_q) begin
        ld     = 1'b1;
        sel_in = sel_q;
        in     = wdata_q;
      end else begin
        oe_a  = 1'b1;
        sel_a = sel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= R0;
      wdata_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
`ifdef REG_ARB_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
`ifdef REG_ARB_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule
